// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  // Address width that the fetch payload struct is built on.
  localparam int unsigned FETCH_XLEN = 64;

  // Width of one instruction in bytes. Sequential fetch advances the PC by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Payload handed to the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0]           raw_instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  is_bubble;
  } fetch_data_t;

  localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'h0, pc: '0, is_bubble: 1'b1};

  typedef enum logic [2:0] {
    F_BOOT,
    F_REQ,
    F_HOLD,
    F_DISCARD,
    F_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and the instruction memory (slave).
interface fetch_stage_if #(
  parameter int unsigned XLEN = 64
) ();

  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that arrived while the pipeline was stalled.
module fetch_skid_buf #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // Entry register; clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= load_instr;
      pc_q    <= load_pc;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, instruction bus handshake, stall buffering and
// redirect handling. Optional misaligned-PC trap is enabled by defining FETCH_MISALIGN_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_stage_if.master     ibus,
  output logic              Iwait,
  output fetch_data_t       dataF
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              fetch_misalign
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            req_valid;
  logic            buf_load, buf_clear;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            buf_valid;
`ifdef FETCH_MISALIGN_EN
  logic            fault_done_q, fault_done_d;
`endif

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (ibus.iresp_data),
    .load_pc    (pc_q),
    .instr      (buf_instr),
    .pc         (buf_pc),
    .valid      (buf_valid)
  );

  // State, PC and pending redirect target registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= F_BOOT;
      pc_q     <= RESET_PC;
      target_q <= '0;
`ifdef FETCH_MISALIGN_EN
      fault_done_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
`ifdef FETCH_MISALIGN_EN
      fault_done_q <= fault_done_d;
`endif
    end
  end

  // Next-state, bus request and fetch output decode; redirect outranks stall and delivery.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    req_valid = 1'b0;
    Iwait     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    dataF     = FETCH_BUBBLE;
`ifdef FETCH_MISALIGN_EN
    fault_done_d   = fault_done_q;
    fetch_misalign = 1'b0;
`endif
    unique case (state_q)
      F_BOOT: begin
        // A stale response from before reset is ignored here.
        state_d = F_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      F_REQ: begin
`ifdef FETCH_MISALIGN_EN
        if (pc_q[1:0] != 2'b00) begin
          // Never put a misaligned address on the bus.
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            state_d      = F_FAULT;
            fault_done_d = 1'b0;
          end
        end else begin
`else
        begin
`endif
          req_valid = 1'b1;
          Iwait     = !ibus.iresp_data_ok;
          if (redirect_valid) begin
            if (ibus.iresp_data_ok) begin
              pc_d = redirect_pc;
            end else begin
              // Request already issued; it must complete before the new target is fetched.
              target_d = redirect_pc;
              state_d  = F_DISCARD;
            end
          end else if (ibus.iresp_data_ok) begin
            if (stall) begin
              buf_load = 1'b1;
              state_d  = F_HOLD;
            end else begin
              dataF = '{raw_instr: ibus.iresp_data, pc: pc_q, is_bubble: 1'b0};
              pc_d  = pc_q + XLEN'(INSTR_BYTES);
            end
          end
        end
      end
      F_HOLD: begin
        if (redirect_valid) begin
          buf_clear = 1'b1;
          pc_d      = redirect_pc;
          state_d   = F_REQ;
        end else if (!stall && buf_valid) begin
          dataF     = '{raw_instr: buf_instr, pc: buf_pc, is_bubble: 1'b0};
          pc_d      = buf_pc + XLEN'(INSTR_BYTES);
          buf_clear = 1'b1;
          state_d   = F_REQ;
        end
      end
      F_DISCARD: begin
        // Keep presenting the killed address until its response drains.
        req_valid = 1'b1;
        Iwait     = 1'b1;
        if (redirect_valid) target_d = redirect_pc;
        if (ibus.iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : target_q;
          state_d = F_REQ;
        end
      end
`ifdef FETCH_MISALIGN_EN
      F_FAULT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = F_REQ;
        end else if (!fault_done_q && !stall) begin
          dataF          = '{raw_instr: 32'h0, pc: pc_q, is_bubble: 1'b0};
          fetch_misalign = 1'b1;
          fault_done_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = F_BOOT;
      end
    endcase
  end

  assign ibus.ireq_valid = req_valid;
  assign ibus.ireq_addr  = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based scoreboard and a single monitor process.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    string       name;
    bit          is_reset;
    bit          valid;
    logic [63:0] addr;
    bit          iwait;
    bit          bubble;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        Iwait;
  fetch_data_t dataF;
  logic        bus_en;
  int          lat;
  int          wait_cnt;
  bit          done;
  int          n_total;
  int          n_pass;
  exp_t        exp_q[$];
  bus_exp_t    bus_q[$];

`ifdef FETCH_MISALIGN_EN
  logic fetch_misalign;
`endif

  fetch_stage_if #(.XLEN(64)) ibus ();

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus           (ibus),
    .Iwait          (Iwait),
    .dataF          (dataF)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  // Instruction memory: answers after lat wait cycles, gated by bus_en.
  assign ibus.iresp_data_ok = ibus.ireq_valid && bus_en && (wait_cnt >= lat);
  assign ibus.iresp_data    = instr_of(ibus.ireq_addr);

  always @(posedge clk) begin
    if (!reset || !ibus.ireq_valid || ibus.iresp_data_ok) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Monitor: pops bus expectations each cycle, delivered instructions whenever dataF is valid.
  always @(negedge clk) begin
    bus_exp_t b;
    exp_t     e;
    if (bus_q.size() > 0) begin
      b = bus_q.pop_front();
      cmp({b.name, " ireq_valid"}, 64'(ibus.ireq_valid), 64'(b.valid));
      if (b.valid) cmp({b.name, " ireq_addr"}, ibus.ireq_addr, b.addr);
      cmp({b.name, " Iwait"}, 64'(Iwait), 64'(b.iwait));
      cmp({b.name, " is_bubble"}, 64'(dataF.is_bubble), 64'(b.bubble));
      if (b.is_reset) begin
        cmp({b.name, " raw_instr"}, 64'(dataF.raw_instr), 64'h0);
        cmp({b.name, " pc"}, dataF.pc, 64'h0);
      end
    end
    if (reset && !dataF.is_bubble) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL deliver: got pc=%h instr=%h, want no delivery", dataF.pc, dataF.raw_instr);
      end else begin
        e = exp_q.pop_front();
        cmp("deliver pc", dataF.pc, e.pc);
        cmp("deliver instr", 64'(dataF.raw_instr), 64'(e.instr));
      end
    end
    if (done) begin
      cmp("pending deliveries", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input bit v, input logic [63:0] a, input bit iw,
                      input bit bub);
    bus_exp_t b;
    b = '{name: name, is_reset: 1'b0, valid: v, addr: a, iwait: iw, bubble: bub};
    bus_q.push_back(b);
    idle();
  endtask

  task automatic expect_fetch(input logic [63:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = instr_of(a);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    bus_exp_t b;
    reset          = 1'b0;
    bus_en         = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    idle();
    b = '{name: "reset", is_reset: 1'b1, valid: 1'b0, addr: '0, iwait: 1'b0, bubble: 1'b1};
    bus_q.push_back(b);
    idle();
  endtask

  task automatic release_reset(input int l);
    reset  = 1'b1;
    bus_en = 1'b1;
    lat    = l;
    step("boot", 1'b0, 64'h0, 1'b0, 1'b1);
  endtask

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  initial begin
    n_total = 0;
    n_pass  = 0;
    done    = 1'b0;
    lat     = 0;
    do_reset();

    // Back-to-back single-cycle bus.
    release_reset(0);
    expect_fetch(B);
    expect_fetch(B + 4);
    expect_fetch(B + 8);
    step("seq0", 1'b1, B, 1'b0, 1'b0);
    step("seq1", 1'b1, B + 4, 1'b0, 1'b0);
    step("seq2", 1'b1, B + 8, 1'b0, 1'b0);
    do_reset();

    // Three-cycle bus latency.
    release_reset(3);
    expect_fetch(B);
    for (int i = 0; i < 3; i++) step("lat wait", 1'b1, B, 1'b1, 1'b1);
    step("lat data", 1'b1, B, 1'b0, 1'b0);
    step("lat next", 1'b1, B + 4, 1'b1, 1'b1);
    do_reset();

    // Stall during delivery, held two more cycles.
    release_reset(0);
    expect_fetch(B);
    step("st d0", 1'b1, B, 1'b0, 1'b0);
    stall = 1'b1;
    step("st cap", 1'b1, B + 4, 1'b0, 1'b1);
    step("st hold1", 1'b0, 64'h0, 1'b0, 1'b1);
    step("st hold2", 1'b0, 64'h0, 1'b0, 1'b1);
    stall = 1'b0;
    expect_fetch(B + 4);
    step("st release", 1'b0, 64'h0, 1'b0, 1'b0);
    expect_fetch(B + 8);
    step("st next", 1'b1, B + 8, 1'b0, 1'b0);
    do_reset();

    // Redirects: discard, last-wins, vs stall, in hold, wrap.
    release_reset(0);
    for (int i = 0; i < 4; i++) expect_fetch(B + 64'(4 * i));
    for (int i = 0; i < 4; i++) step("rd pre", 1'b1, B + 64'(4 * i), 1'b0, 1'b0);
    lat            = 2;
    redirect_valid = 1'b1;
    redirect_pc    = B + 64'h100;
    step("rd kill", 1'b1, B + 64'h10, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    step("rd drain1", 1'b1, B + 64'h10, 1'b1, 1'b1);
    lat = 0;
    step("rd drain2", 1'b1, B + 64'h10, 1'b1, 1'b1);
    expect_fetch(B + 64'h100);
    step("rd target", 1'b1, B + 64'h100, 1'b0, 1'b0);

    lat            = 2;
    redirect_valid = 1'b1;
    redirect_pc    = B + 64'h200;
    step("rd2 kill", 1'b1, B + 64'h104, 1'b1, 1'b1);
    redirect_pc = B + 64'h300;
    step("rd2 over", 1'b1, B + 64'h104, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    step("rd2 drain", 1'b1, B + 64'h104, 1'b1, 1'b1);
    lat = 0;
    expect_fetch(B + 64'h300);
    step("rd2 target", 1'b1, B + 64'h300, 1'b0, 1'b0);

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = B + 64'h400;
    step("rd stall", 1'b1, B + 64'h304, 1'b0, 1'b1);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    expect_fetch(B + 64'h400);
    step("rd stall tgt", 1'b1, B + 64'h400, 1'b0, 1'b0);

    stall = 1'b1;
    step("rd hold cap", 1'b1, B + 64'h404, 1'b0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = B + 64'h500;
    step("rd hold", 1'b0, 64'h0, 1'b0, 1'b1);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    expect_fetch(B + 64'h500);
    step("rd hold tgt", 1'b1, B + 64'h500, 1'b0, 1'b0);

    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_fffc;
    step("wrap redir", 1'b1, B + 64'h504, 1'b0, 1'b1);
    redirect_valid = 1'b0;
    expect_fetch(64'hffff_ffff_ffff_fffc);
    step("wrap top", 1'b1, 64'hffff_ffff_ffff_fffc, 1'b0, 1'b0);
    expect_fetch(64'h0);
    step("wrap zero", 1'b1, 64'h0, 1'b0, 1'b0);
    do_reset();

    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL end: monitor did not finish, want summary");
    $fatal(1);
  end

endmodule
